// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and default widths/addresses.
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // Must match the default_increment of the PC Register feeding this stage.
  localparam int          PC_STEP          = 4;
  // Reserved for bubble insertion toward decode.
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register for the fetched instruction and its address toward decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic            i_consume,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_pc;

  // Clear (redirect) and consume both empty the entry; emptying wins over a load.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_clear || i_consume) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC Register, issues one instruction-memory request at a time and buffers the result.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  fetch_state_e    r_state;
  fetch_state_e    w_stateNext;
  logic            r_drop;
  logic            w_dropNext;
  logic [XLEN-1:0] r_reqPc;
  logic            w_latchReqPc;
  logic            w_bufLoad;
  logic            w_bufClear;
  logic            w_bufConsume;
  logic [XLEN-1:0] w_redirectPc;

  assign w_redirectPc = redirect_target & ~XLEN'(3);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_drop  <= 1'b0;
      r_reqPc <= '0;
    end else begin
      r_state <= w_stateNext;
      r_drop  <= w_dropNext;
      if (w_latchReqPc) begin
        r_reqPc <= pc;
      end
    end
  end

  // Redirect outranks everything outside BOOT; an in-flight response after a redirect is dropped.
  always_comb begin
    w_stateNext  = r_state;
    w_dropNext   = r_drop;
    w_latchReqPc = 1'b0;
    w_bufLoad    = 1'b0;
    w_bufClear   = 1'b0;
    w_bufConsume = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    pc_next      = '0;
    imem_req     = 1'b0;
    imem_addr    = pc;

    unique case (r_state)
      ST_BOOT: begin
        pc_load     = 1'b1;
        pc_next     = RESET_PC;
        w_stateNext = ST_REQ;
      end

      ST_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_load = 1'b1;
          pc_next = w_redirectPc;
          if (imem_ready) begin
            w_dropNext  = 1'b1;
            w_stateNext = ST_WAIT;
          end
        end else if (imem_ready) begin
          pc_inc       = 1'b1;
          w_latchReqPc = 1'b1;
          w_stateNext  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          pc_next = w_redirectPc;
          if (imem_rvalid) begin
            w_dropNext  = 1'b0;
            w_stateNext = ST_REQ;
          end else begin
            w_dropNext = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (r_drop) begin
            w_dropNext  = 1'b0;
            w_stateNext = ST_REQ;
          end else begin
            w_bufLoad   = 1'b1;
            w_stateNext = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        if (redirect_valid) begin
          pc_load     = 1'b1;
          pc_next     = w_redirectPc;
          w_bufClear  = 1'b1;
          w_stateNext = ST_REQ;
        end else if (instr_ready) begin
          w_bufConsume = 1'b1;
          w_stateNext  = ST_REQ;
        end
      end

      default: begin
        w_stateNext = ST_BOOT;
      end
    endcase
  end

  fetch_buffer #(
    .XLEN(XLEN)
  ) u_fetchBuffer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_bufLoad),
    .i_clear  (w_bufClear),
    .i_consume(w_bufConsume),
    .i_data   (imem_rdata),
    .i_pc     (r_reqPc),
    .o_valid  (instr_valid),
    .o_data   (instr_data),
    .o_pc     (instr_pc)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a behavioural PC Register closing the loop.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pcReg = 32'hDEAD_BEEC;

  always #5 clock = ~clock;

  // PC Register model: no reset, load has priority, default increment of 4.
  always @(posedge clock) begin
    if (pc_load) pcReg <= pc_next;
    else if (pc_inc) pcReg <= pcReg + 32'd4;
  end
  assign pc = pcReg;

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .pc_inc         (pc_inc),
    .pc_load        (pc_load),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  task automatic nextCycle;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h500;
    @(negedge clock);
    checks++; if (pc_load !== 1'b1) begin failures++; $display("[TB] FAIL boot_pc_load actual=%0b required=1", pc_load); end
    checks++; if (pc_next !== 32'h0) begin failures++; $display("[TB] FAIL boot_pc_next actual=%h required=0 (redirect ignored)", pc_next); end
    checks++; if (pc_inc !== 1'b0) begin failures++; $display("[TB] FAIL boot_pc_inc actual=%0b required=0", pc_inc); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL boot_imem_req actual=%0b required=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL boot_instr_valid actual=%0b required=0", instr_valid); end
    checks++; if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL boot_instr_regs data=%h pc=%h required 0/0", instr_data, instr_pc); end
  endtask

  task automatic test_first_fetch;
    nextCycle();
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL first_req req=%0b addr=%h required 1/0", imem_req, imem_addr); end
    checks++; if (pc_inc !== 1'b1 || pc_load !== 1'b0) begin failures++; $display("[TB] FAIL first_pc_ctrl inc=%0b load=%0b required 1/0", pc_inc, pc_load); end
    nextCycle();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hAAA0;
    @(negedge clock);
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL first_wait req=%0b valid=%0b required 0/0", imem_req, instr_valid); end
    nextCycle();
    imem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'hAAA0 || instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL first_out valid=%0b data=%h pc=%h required 1/0000aaa0/0", instr_valid, instr_data, instr_pc); end
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] expAddr;
      logic [31:0] word;
      expAddr = 32'(i * 4);
      word = 32'h1000_0000 + 32'(i);
      nextCycle();
      instr_ready = 1'b1;
      @(negedge clock);
      checks++; if (pc_inc !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL seq_out_idle[%0d] inc=%0b req=%0b required 0/0", i, pc_inc, imem_req); end
      nextCycle();
      instr_ready = 1'b0;
      imem_ready = 1'b1;
      @(negedge clock);
      checks++; if (imem_req !== 1'b1 || imem_addr !== expAddr) begin failures++; $display("[TB] FAIL seq_addr[%0d] req=%0b addr=%h required 1/%h", i, imem_req, imem_addr, expAddr); end
      checks++; if (pc_inc !== 1'b1 || pc_load !== 1'b0) begin failures++; $display("[TB] FAIL seq_pc_ctrl[%0d] inc=%0b load=%0b required 1/0", i, pc_inc, pc_load); end
      nextCycle();
      imem_ready = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = word;
      @(negedge clock);
      checks++; if (instr_valid !== 1'b0 || pc_inc !== 1'b0) begin failures++; $display("[TB] FAIL seq_wait[%0d] valid=%0b inc=%0b required 0/0", i, instr_valid, pc_inc); end
      nextCycle();
      imem_rvalid = 1'b0;
      @(negedge clock);
      checks++; if (instr_valid !== 1'b1 || instr_data !== word || instr_pc !== expAddr) begin failures++; $display("[TB] FAIL seq_out[%0d] valid=%0b data=%h pc=%h required 1/%h/%h", i, instr_valid, instr_data, instr_pc, word, expAddr); end
    end
  endtask

  task automatic test_back_pressure;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      instr_ready = 1'b0;
      @(negedge clock);
      checks++; if (instr_valid !== 1'b1 || instr_data !== 32'h1000_0003 || instr_pc !== 32'hC) begin failures++; $display("[TB] FAIL bp_hold[%0d] valid=%0b data=%h pc=%h required 1/10000003/c", i, instr_valid, instr_data, instr_pc); end
      checks++; if (imem_req !== 1'b0 || pc_inc !== 1'b0) begin failures++; $display("[TB] FAIL bp_quiet[%0d] req=%0b inc=%0b required 0/0", i, imem_req, pc_inc); end
    end
    nextCycle();
    instr_ready = 1'b1;
    nextCycle();
    instr_ready = 1'b0;
    imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc_inc !== 1'b1) begin failures++; $display("[TB] FAIL bp_release req=%0b addr=%h inc=%0b required 1/10/1", imem_req, imem_addr, pc_inc); end
    nextCycle();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h2000_0010;
    nextCycle();
    imem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'h2000_0010 || instr_pc !== 32'h10) begin failures++; $display("[TB] FAIL bp_out valid=%0b data=%h pc=%h required 1/20000010/10", instr_valid, instr_data, instr_pc); end
  endtask

  task automatic test_redirect_wait;
    nextCycle();
    instr_ready = 1'b1;
    nextCycle();
    instr_ready = 1'b0;
    imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (imem_addr !== 32'h14) begin failures++; $display("[TB] FAIL rw_req_addr actual=%h required=14", imem_addr); end
    nextCycle();
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    @(negedge clock);
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h100 || pc_inc !== 1'b0) begin failures++; $display("[TB] FAIL rw_redirect load=%0b next=%h inc=%0b required 1/100/0", pc_load, pc_next, pc_inc); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rw_no_req actual=%0b required=0", imem_req); end
    nextCycle();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_0001;
    @(negedge clock);
    checks++; if (imem_req !== 1'b0 || pc_load !== 1'b0) begin failures++; $display("[TB] FAIL rw_drop_cycle req=%0b load=%0b required 0/0", imem_req, pc_load); end
    nextCycle();
    imem_rvalid = 1'b0;
    imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rw_dropped_valid actual=%0b required=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL rw_new_addr req=%0b addr=%h required 1/100", imem_req, imem_addr); end
    nextCycle();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h3000_0100;
    nextCycle();
    imem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'h3000_0100 || instr_pc !== 32'h100) begin failures++; $display("[TB] FAIL rw_out valid=%0b data=%h pc=%h required 1/30000100/100", instr_valid, instr_data, instr_pc); end
  endtask

  task automatic test_redirect_req;
    nextCycle();
    instr_ready = 1'b1;
    nextCycle();
    instr_ready = 1'b0;
    imem_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h203;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin failures++; $display("[TB] FAIL rq_req req=%0b addr=%h required 1/104", imem_req, imem_addr); end
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h200 || pc_inc !== 1'b0) begin failures++; $display("[TB] FAIL rq_redirect load=%0b next=%h inc=%0b required 1/200/0", pc_load, pc_next, pc_inc); end
    nextCycle();
    imem_ready = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_0002;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rq_wait valid=%0b req=%0b required 0/0", instr_valid, imem_req); end
    nextCycle();
    imem_rvalid = 1'b0;
    imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rq_dropped_valid actual=%0b required=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || pc_inc !== 1'b1) begin failures++; $display("[TB] FAIL rq_new_addr req=%0b addr=%h inc=%0b required 1/200/1", imem_req, imem_addr, pc_inc); end
    nextCycle();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h4000_0200;
    nextCycle();
    imem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'h4000_0200 || instr_pc !== 32'h200) begin failures++; $display("[TB] FAIL rq_out valid=%0b data=%h pc=%h required 1/40000200/200", instr_valid, instr_data, instr_pc); end
  endtask

  task automatic test_redirect_out;
    nextCycle();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h302;
    @(negedge clock);
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h300 || pc_inc !== 1'b0) begin failures++; $display("[TB] FAIL ro_redirect load=%0b next=%h inc=%0b required 1/300/0", pc_load, pc_next, pc_inc); end
    nextCycle();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL ro_discard actual=%0b required=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("[TB] FAIL ro_new_addr req=%0b addr=%h required 1/300", imem_req, imem_addr); end
    nextCycle();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h5000_0300;
    nextCycle();
    imem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'h5000_0300 || instr_pc !== 32'h300) begin failures++; $display("[TB] FAIL ro_out valid=%0b data=%h pc=%h required 1/50000300/300", instr_valid, instr_data, instr_pc); end
  endtask

  task automatic test_reset_mid;
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_buffer valid=%0b data=%h pc=%h required 0/0/0", instr_valid, instr_data, instr_pc); end
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h0 || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_boot load=%0b next=%h req=%0b required 1/0/0", pc_load, pc_next, imem_req); end
    nextCycle();
    imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_inc !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_restart req=%0b addr=%h inc=%0b required 1/0/1", imem_req, imem_addr, pc_inc); end
    nextCycle();
    imem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_back_pressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_out();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
